serial_mem_slave: RTL and testbench

- Parametrised serial-bus memory slave; next generation of the fixed 4K-byte bus slave.
- Generalised in address width, data width, memory depth and word-address offset.
- Adds address-range decode with no-ACK for out-of-range addresses, abort on early AD_SEL drop, real read data, and optional auto-incrementing bursts.
- Sits on the shared serial bus behind the bus arbiter/decoder, which drives AD_SEL.

---
 rtl/serial_mem_slave_if.sv | 23 ++
 rtl/serial_mem_slave.sv | 192 +++++++++++++++++++
 tb/tb_serial_mem_slave.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/serial_mem_slave_if.sv
// rtl/serial_mem_slave_if.sv - serial bus signals between master/decoder and memory slave
interface serial_mem_slave_if #(
    parameter int DATA_W = 8
) ();
    logic              AD_SEL;
    logic              B_RW;
    logic              B_BUS_OUT;
    logic              B_BUS_IN;
    logic              B_ACK;
    logic              B_SBSY;
    logic              S_DVALID;
    logic [DATA_W-1:0] S_DOUT;

    modport master (
        output AD_SEL, B_RW, B_BUS_OUT,
        input  B_BUS_IN, B_ACK, B_SBSY, S_DVALID, S_DOUT
    );

    modport slave (
        input  AD_SEL, B_RW, B_BUS_OUT,
        output B_BUS_IN, B_ACK, B_SBSY, S_DVALID, S_DOUT
    );
endinterface

// File: rtl/serial_mem_slave.sv
// rtl/serial_mem_slave.sv - parametrised serial-bus memory slave with range decode and bursts
module serial_mem_slave #(
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 8,
    parameter int MEM_DEPTH = 4096,
    parameter int ADDR_LSB  = 2,
    parameter int BURST_EN  = 1
) (
    input  logic                 CLK,
    input  logic                 RSTN,
    serial_mem_slave_if.slave    bus
);
    localparam int IDX_W = $clog2(MEM_DEPTH);
    localparam int MAX_W = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
    localparam int CNT_W = $clog2(MAX_W);

    localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_W - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_ADDR  = 3'd1;
    localparam logic [2:0] ST_ACK_A = 3'd2;
    localparam logic [2:0] ST_WRITE = 3'd3;
    localparam logic [2:0] ST_ACK_W = 3'd4;
    localparam logic [2:0] ST_READ  = 3'd5;

    logic [2:0]        state;
    logic [CNT_W-1:0]  cnt;
    logic [ADDR_W-1:0] addr;
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-2:0] wr_sh;
    logic [DATA_W-2:0] rd_sh;
    logic              ack_q;
    logic              sbsy_q;
    logic              bin_q;
    logic              dv_q;
    logic [DATA_W-1:0] dout_q;

    logic [DATA_W-1:0] mem [MEM_DEPTH];

    logic [ADDR_W-1:0] addr_n;
    logic [IDX_W-1:0]  idx_n;
    logic [IDX_W-1:0]  idx_inc;
    logic              in_range;
    logic [DATA_W-1:0] wr_word;
    logic [DATA_W-1:0] rd_cur;
    logic [DATA_W-1:0] rd_nxt;
    logic              mem_we;
    logic              burst_go;
    logic              unused_addr_bits;

    // Address and data arrive LSB first, so both are shifted in from the top
    assign addr_n   = {bus.B_BUS_OUT, addr[ADDR_W-1:1]};
    assign idx_n    = addr_n[ADDR_LSB+IDX_W-1:ADDR_LSB];
    assign in_range = ((addr_n >> (ADDR_LSB + IDX_W)) == '0);
    assign idx_inc  = idx + IDX_W'(1);
    assign wr_word  = {bus.B_BUS_OUT, wr_sh};
    assign rd_cur   = mem[idx];
    assign rd_nxt   = mem[idx_inc];
    assign mem_we   = (state == ST_WRITE) && (cnt == DATA_LAST) && RSTN;
    assign burst_go = (BURST_EN != 0) && bus.AD_SEL;

    assign unused_addr_bits = ^{addr_n, addr[0]};

    assign bus.B_ACK    = ack_q;
    assign bus.B_SBSY   = sbsy_q;
    assign bus.B_BUS_IN = bin_q;
    assign bus.S_DVALID = dv_q;
    assign bus.S_DOUT   = dout_q;

    always_ff @(posedge CLK) begin
        if (mem_we) begin
            mem[idx] <= wr_word;
        end
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            addr   <= '0;
            idx    <= '0;
            wr_sh  <= '0;
            rd_sh  <= '0;
            ack_q  <= 1'b0;
            sbsy_q <= 1'b0;
            bin_q  <= 1'b0;
            dv_q   <= 1'b0;
            dout_q <= '0;
        end else begin
            dv_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.AD_SEL) begin
                        state  <= ST_ADDR;
                        cnt    <= '0;
                        sbsy_q <= 1'b1;
                    end
                end
                ST_ADDR: begin
                    if (!bus.AD_SEL) begin
                        state  <= ST_IDLE;
                        cnt    <= '0;
                        sbsy_q <= 1'b0;
                    end else if (cnt == ADDR_LAST) begin
                        addr <= addr_n;
                        cnt  <= '0;
                        if (in_range) begin
                            state <= ST_ACK_A;
                            idx   <= idx_n;
                            ack_q <= 1'b1;
                        end else begin
                            // out-of-range addresses are refused by never acknowledging
                            state  <= ST_IDLE;
                            sbsy_q <= 1'b0;
                        end
                    end else begin
                        addr <= addr_n;
                        cnt  <= cnt + CNT_W'(1);
                    end
                end
                ST_ACK_A: begin
                    ack_q <= 1'b0;
                    if (cnt == '0) begin
                        cnt <= CNT_W'(1);
                    end else begin
                        cnt <= '0;
                        if (bus.B_RW) begin
                            state <= ST_WRITE;
                        end else begin
                            state <= ST_READ;
                            bin_q <= rd_cur[0];
                            rd_sh <= rd_cur[DATA_W-1:1];
                        end
                    end
                end
                ST_WRITE: begin
                    if (cnt == DATA_LAST) begin
                        state  <= ST_ACK_W;
                        cnt    <= '0;
                        ack_q  <= 1'b1;
                        dv_q   <= 1'b1;
                        dout_q <= wr_word;
                    end else begin
                        wr_sh <= {bus.B_BUS_OUT, wr_sh[DATA_W-2:1]};
                        cnt   <= cnt + CNT_W'(1);
                    end
                end
                ST_ACK_W: begin
                    if (cnt == '0) begin
                        cnt <= CNT_W'(1);
                    end else begin
                        cnt   <= '0;
                        ack_q <= 1'b0;
                        if (burst_go) begin
                            state <= ST_WRITE;
                            idx   <= idx_inc;
                        end else begin
                            state  <= ST_IDLE;
                            sbsy_q <= 1'b0;
                        end
                    end
                end
                ST_READ: begin
                    if (cnt == DATA_LAST) begin
                        cnt <= '0;
                        if (burst_go) begin
                            idx   <= idx_inc;
                            bin_q <= rd_nxt[0];
                            rd_sh <= rd_nxt[DATA_W-1:1];
                        end else begin
                            state  <= ST_IDLE;
                            sbsy_q <= 1'b0;
                            bin_q  <= 1'b0;
                        end
                    end else begin
                        bin_q <= rd_sh[0];
                        rd_sh <= rd_sh >> 1;
                        cnt   <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    cnt    <= '0;
                    ack_q  <= 1'b0;
                    sbsy_q <= 1'b0;
                    bin_q  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_serial_mem_slave.sv
// tb/tb_serial_mem_slave.sv - self-checking bench for serial_mem_slave
module tb_serial_mem_slave;
    logic CLK = 1'b0;
    logic RSTN;
    always #5 CLK = ~CLK;

    serial_mem_slave_if #(.DATA_W(8)) ifc ();
    serial_mem_slave_if #(.DATA_W(8)) ifc_nb ();

    assign ifc_nb.AD_SEL    = ifc.AD_SEL;
    assign ifc_nb.B_RW      = ifc.B_RW;
    assign ifc_nb.B_BUS_OUT = ifc.B_BUS_OUT;

    serial_mem_slave #(.BURST_EN(1)) u_dut (.CLK(CLK), .RSTN(RSTN), .bus(ifc.slave));
    serial_mem_slave #(.BURST_EN(0)) u_nb  (.CLK(CLK), .RSTN(RSTN), .bus(ifc_nb.slave));

    int n_run  = 0;
    int n_fail = 0;

    logic [7:0] m_mem [int];
    logic [7:0] m_dout = 8'h00;
    logic e_ack = 1'b0, e_sbsy = 1'b0, e_bin = 1'b0, e_dv = 1'b0;
    bit   chk_en = 1'b0;
    int   dv_cnt = 0;
    int   nb_dv_cnt = 0;

    logic [7:0] wq [$];
    logic [7:0] rd_got [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge CLK) begin
        if (chk_en) begin
            check("B_ACK", {31'd0, ifc.B_ACK}, {31'd0, e_ack});
            check("B_SBSY", {31'd0, ifc.B_SBSY}, {31'd0, e_sbsy});
            check("B_BUS_IN", {31'd0, ifc.B_BUS_IN}, {31'd0, e_bin});
            check("S_DVALID", {31'd0, ifc.S_DVALID}, {31'd0, e_dv});
            check("S_DOUT", {24'd0, ifc.S_DOUT}, {24'd0, m_dout});
            if (ifc.S_DVALID === 1'b1) dv_cnt++;
            if (ifc_nb.S_DVALID === 1'b1) nb_dv_cnt++;
        end
    end

    task automatic cyc(input logic sel, input logic rw, input logic bo);
        ifc.AD_SEL    = sel;
        ifc.B_RW      = rw;
        ifc.B_BUS_OUT = bo;
        @(posedge CLK);
        #1;
    endtask

    task automatic expo(input logic ack, input logic sbsy, input logic bin, input logic dv);
        e_ack  = ack;
        e_sbsy = sbsy;
        e_bin  = bin;
        e_dv   = dv;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            cyc(1'b0, 1'b0, 1'b0);
            expo(1'b0, 1'b0, 1'b0, 1'b0);
        end
    endtask

    // One bus transaction; abort_at drops AD_SEL at that address bit, rst_bit resets after that many data bits
    task automatic xfer(input logic [15:0] addr, input logic rw, input int nw,
                        input int abort_at, input int rst_bit);
        int         idx;
        logic [7:0] word;
        logic [7:0] got;
        rd_got.delete();
        cyc(1'b1, 1'b0, 1'b0);
        expo(1'b0, 1'b1, 1'b0, 1'b0);
        for (int b = 0; b < 16; b++) begin
            if (b == abort_at) begin
                cyc(1'b0, 1'b0, 1'b0);
                expo(1'b0, 1'b0, 1'b0, 1'b0);
                return;
            end
            cyc(1'b1, 1'b0, addr[b]);
            if (b < 15) expo(1'b0, 1'b1, 1'b0, 1'b0);
        end
        if (addr[15:14] != 2'b00) begin
            expo(1'b0, 1'b0, 1'b0, 1'b0);
            return;
        end
        idx = int'(addr[13:2]);
        expo(1'b1, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        expo(1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, rw, 1'b0);
        if (rw) begin
            expo(1'b0, 1'b1, 1'b0, 1'b0);
            for (int w = 0; w < nw; w++) begin
                word = wq[w];
                for (int k = 0; k < 8; k++) begin
                    if (k == rst_bit) begin
                        RSTN = 1'b0;
                        ifc.AD_SEL = 1'b0;
                        ifc.B_BUS_OUT = 1'b0;
                        m_dout = 8'h00;
                        expo(1'b0, 1'b0, 1'b0, 1'b0);
                        #1;
                        check("rst_ack", {31'd0, ifc.B_ACK}, 32'd0);
                        check("rst_sbsy", {31'd0, ifc.B_SBSY}, 32'd0);
                        check("rst_dv", {31'd0, ifc.S_DVALID}, 32'd0);
                        check("rst_dout", {24'd0, ifc.S_DOUT}, 32'd0);
                        check("rst_nb_sbsy", {31'd0, ifc_nb.B_SBSY}, 32'd0);
                        @(posedge CLK);
                        #1;
                        RSTN = 1'b1;
                        return;
                    end
                    cyc(1'b1, 1'b0, word[k]);
                    if (k < 7) expo(1'b0, 1'b1, 1'b0, 1'b0);
                end
                m_mem[idx] = word;
                m_dout = word;
                expo(1'b1, 1'b1, 1'b0, 1'b1);
                cyc(1'b1, 1'b0, 1'b0);
                expo(1'b1, 1'b1, 1'b0, 1'b0);
                cyc(w < nw - 1, 1'b0, 1'b0);
                if (w < nw - 1) begin
                    idx = (idx + 1) % 4096;
                    expo(1'b0, 1'b1, 1'b0, 1'b0);
                    check("nb_ends_idle", {31'd0, ifc_nb.B_SBSY}, 32'd0);
                end else begin
                    expo(1'b0, 1'b0, 1'b0, 1'b0);
                end
            end
        end else begin
            word = m_mem[idx];
            expo(1'b0, 1'b1, word[0], 1'b0);
            for (int w = 0; w < nw; w++) begin
                word = m_mem[idx];
                got[0] = ifc.B_BUS_IN;
                for (int k = 0; k < 7; k++) begin
                    cyc(1'b1, 1'b0, 1'b0);
                    expo(1'b0, 1'b1, word[k+1], 1'b0);
                    got[k+1] = ifc.B_BUS_IN;
                end
                rd_got.push_back(got);
                cyc(w < nw - 1, 1'b0, 1'b0);
                if (w < nw - 1) begin
                    idx = (idx + 1) % 4096;
                    word = m_mem[idx];
                    expo(1'b0, 1'b1, word[0], 1'b0);
                end else begin
                    expo(1'b0, 1'b0, 1'b0, 1'b0);
                end
            end
        end
    endtask

    initial begin
        RSTN = 1'b0;
        ifc.AD_SEL = 1'b0;
        ifc.B_RW = 1'b0;
        ifc.B_BUS_OUT = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        check("reset_ack", {31'd0, ifc.B_ACK}, 32'd0);
        check("reset_sbsy", {31'd0, ifc.B_SBSY}, 32'd0);
        check("reset_bin", {31'd0, ifc.B_BUS_IN}, 32'd0);
        check("reset_dv", {31'd0, ifc.S_DVALID}, 32'd0);
        check("reset_dout", {24'd0, ifc.S_DOUT}, 32'd0);
        RSTN = 1'b1;
        chk_en = 1'b1;
        idle(2);

        wq = '{8'hA5};
        xfer(16'h0010, 1'b1, 1, -1, -1);
        idle(2);
        xfer(16'h0010, 1'b0, 1, -1, -1);
        check("read_a5", {24'd0, rd_got[0]}, 32'h0000_00A5);
        idle(1);

        xfer(16'h0000, 1'b1, 1, 5, -1);
        wq = '{8'h3C};
        xfer(16'h0000, 1'b1, 1, -1, -1);
        idle(1);

        xfer(16'hC000, 1'b0, 1, -1, -1);
        idle(1);
        xfer(16'h0000, 1'b0, 1, -1, -1);
        check("oor_keeps_3c", {24'd0, rd_got[0]}, 32'h0000_003C);
        idle(1);

        wq = '{8'h11, 8'h22};
        dv_cnt = 0;
        nb_dv_cnt = 0;
        xfer(16'h3FFC, 1'b1, 2, -1, -1);
        idle(2);
        check("burst_dv_pulses", dv_cnt, 2);
        check("nb_dv_pulses", nb_dv_cnt, 1);
        xfer(16'h3FFC, 1'b0, 2, -1, -1);
        check("burst_rd_4095", {24'd0, rd_got[0]}, 32'h0000_0011);
        check("burst_rd_0", {24'd0, rd_got[1]}, 32'h0000_0022);
        idle(1);

        wq = '{8'h5A};
        xfer(16'h0010, 1'b1, 1, -1, 4);
        idle(2);
        xfer(16'h0010, 1'b0, 1, -1, -1);
        check("rst_keeps_a5", {24'd0, rd_got[0]}, 32'h0000_00A5);
        idle(2);

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
